// File: rtl/clarvi_dial_pkg.sv
// Shared types for the dial poller: dial width, poll FSM states, wrap-around delta.
// Used by clarvi_soc_dial_poller (optional DIAL_POLLER_DEBOUNCE_EN) and its poll timer.
package clarvi_dial_pkg;

    localparam int DIAL_W = 8;
    localparam int CNT_W  = 24;

    typedef logic [DIAL_W-1:0] dial_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        EMIT
    } poll_state_e;

    // Modulo-256 difference; read as two's complement, so large jumps alias.
    function automatic dial_t wrap_delta(input dial_t nv, input dial_t ov);
        return nv - ov;
    endfunction

endpackage

// File: rtl/clarvi_dial_poll_timer.sv
// Free-running poll-rate counter with a terminal-count pulse and a one-deep pending flag
// that remembers a terminal count the FSM could not act on immediately.
module clarvi_dial_poll_timer
    import clarvi_dial_pkg::*;
#(
    parameter int unsigned POLL_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic take_i,
    output logic tc_o,
    output logic pend_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             tc;

    always_comb begin
        tc    = en_i && (cnt_q == TC_VAL);
        cnt_d = cnt_q;
        if (tc)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
        // A poll start consumed this cycle clears the flag; otherwise a tick arms it.
        pend_d = pend_q;
        if (take_i)
            pend_d = 1'b0;
        else if (tc)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign tc_o   = tc;
    assign pend_o = pend_q;

endmodule

// File: rtl/clarvi_soc_dial_poller.sv
// Avalon-MM master polling an 8-bit dial port and streaming value/delta change events.
// Define DIAL_POLLER_DEBOUNCE_EN to require two matching differing samples per event.
module clarvi_soc_dial_poller
    import clarvi_dial_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned      POLL_DIV  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [7:0]        evt_value,
    output logic [7:0]        evt_delta
);

    poll_state_e state_q, state_d;
    dial_t       last_q, last_d;
    logic        primed_q, primed_d;
    dial_t       val_q, val_d;
    dial_t       dlt_q, dlt_d;
    logic        tc, pend, take, chg_ok;
    dial_t       s;
    logic        unused_rd;

    assign s         = avm_readdata[DIAL_W-1:0];
    assign unused_rd = ^avm_readdata[31:DIAL_W];

    clarvi_dial_poll_timer #(
        .POLL_DIV(POLL_DIV)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en_i  (enable),
        .take_i(take),
        .tc_o  (tc),
        .pend_o(pend)
    );

`ifdef DIAL_POLLER_DEBOUNCE_EN
    dial_t cand_q, cand_d;
    logic  cand_vld_q, cand_vld_d;

    assign chg_ok = cand_vld_q && (s == cand_q);

    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        if (state_q == WAIT && avm_readdatavalid && primed_q) begin
            if (s == last_q || chg_ok) begin
                cand_vld_d = 1'b0;
            end else begin
                cand_d     = s;
                cand_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
        end
    end
`else
    assign chg_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        primed_d = primed_q;
        val_d    = val_q;
        dlt_d    = dlt_q;
        take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (tc || pend)) begin
                    take    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!avm_waitrequest)
                    state_d = WAIT;
            end
            WAIT: begin
                // enable is deliberately ignored: an issued read always completes.
                if (avm_readdatavalid) begin
                    state_d = IDLE;
                    if (!primed_q) begin
                        last_d   = s;
                        primed_d = 1'b1;
                    end else if (s != last_q && chg_ok) begin
                        val_d   = s;
                        dlt_d   = wrap_delta(s, last_q);
                        last_d  = s;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                // A tick seen while blocked starts the next read right after the handshake.
                if (evt_ready) begin
                    if (enable && (tc || pend)) begin
                        take    = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= '0;
            primed_q <= 1'b0;
            val_q    <= '0;
            dlt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            primed_q <= primed_d;
            val_q    <= val_d;
            dlt_q    <= dlt_d;
        end
    end

    assign avm_address = BASE_ADDR;
    assign avm_read    = (state_q == REQ);
    assign evt_valid   = (state_q == EMIT);
    assign evt_value   = val_q;
    assign evt_delta   = dlt_q;

endmodule

// File: tb/tb_clarvi_soc_dial_poller.sv
// Directed bench for clarvi_soc_dial_poller with a variable-stall Avalon slave model.
// Extra glitch/confirm vectors run when DIAL_POLLER_DEBOUNCE_EN is defined.
module tb_clarvi_soc_dial_poller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [7:0]  evt_value;
    logic [7:0]  evt_delta;

    logic [7:0]  dial = 8'h10;
    int          stall_cfg = 0;
    int          stall_cnt = 0;

    int          n_cmp = 0;
    int          n_bad = 0;

    int          cyc = 0;
    int          nreads = 0;
    int          acc_prev = 0;
    int          acc_last = 0;
    int          nhs = 0;
    int          evhi = 0;
    int          last_rdv_cyc = 0;
    int          rise_cyc = 0;
    int          rd_run = 0;
    int          last_rd_run = 0;
    logic        evt_valid_d = 1'b0;
    logic [7:0]  hs_val = '0;
    logic [7:0]  hs_dlt = '0;

    clarvi_soc_dial_poller #(
        .ADDR_W   (32),
        .BASE_ADDR(32'h0),
        .POLL_DIV (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_value        (evt_value),
        .evt_delta        (evt_delta)
    );

    always #5 clk = ~clk;

    // Slave: stall_cfg wait states per request, then data one cycle after acceptance.
    assign avm_waitrequest = avm_read && (stall_cnt < stall_cfg);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_readdatavalid <= 1'b0;
            stall_cnt         <= 0;
        end else begin
            avm_readdatavalid <= 1'b0;
            if (avm_read) begin
                if (stall_cnt < stall_cfg) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt         <= 0;
                    avm_readdatavalid <= 1'b1;
                    avm_readdata      <= {24'h0, dial};
                    nreads            <= nreads + 1;
                    acc_prev          <= acc_last;
                    acc_last          <= cyc;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        evt_valid_d <= evt_valid;
        if (avm_readdatavalid) last_rdv_cyc <= cyc;
        if (evt_valid && !evt_valid_d) rise_cyc <= cyc;
        if (evt_valid) evhi <= evhi + 1;
        if (evt_valid && evt_ready) begin
            nhs    <= nhs + 1;
            hs_val <= evt_value;
            hs_dlt <= evt_delta;
        end
        if (avm_read) begin
            rd_run <= rd_run + 1;
        end else begin
            if (rd_run != 0) last_rd_run <= rd_run;
            rd_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_hs(input int tgt);
        int k = 0;
        while (nhs < tgt && k < 100) begin
            tick(1);
            k++;
        end
        chk("hs_timeout", 32'(nhs >= tgt), 32'd1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!evt_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk("valid_timeout", 32'(evt_valid), 32'd1);
    endtask

    task automatic wait_rd();
        int k = 0;
        while (!avm_read && k < 100) begin
            tick(1);
            k++;
        end
        chk("read_timeout", 32'(avm_read), 32'd1);
    endtask

    task automatic wait_acc();
        int n0 = nreads;
        int k = 0;
        while (nreads == n0 && k < 100) begin
            tick(1);
            k++;
        end
        chk("acc_timeout", 32'(nreads != n0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, e0, r0;

        // 1: reset state, priming read, 4-cycle poll period, no events
        #2;
        chk("rst_read",  32'(avm_read),  32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_value", 32'(evt_value), 32'h00);
        chk("rst_delta", 32'(evt_delta), 32'h00);
        chk("rst_addr",  avm_address,    32'h0);
        tick(2);
        reset  = 1'b0;
        enable = 1'b1;
        tick(24);
        chk("prime_no_evt", 32'(nhs),  32'd0);
        chk("prime_no_hi",  32'(evhi), 32'd0);
        chk("poll_gap",     32'(acc_last - acc_prev), 32'd4);
        chk("poll_count",   32'(nreads >= 5), 32'd1);

        // 2: 10 -> 13, single-cycle event one cycle after readdatavalid
        n0 = nhs;
        e0 = evhi;
        dial = 8'h13;
        wait_hs(n0 + 1);
        chk("step_val",     32'(hs_val), 32'h13);
        chk("step_dlt",     32'(hs_dlt), 32'h03);
        chk("step_width",   32'(evhi - e0), 32'd1);
        chk("step_latency", 32'(rise_cyc - last_rdv_cyc), 32'd1);
        tick(20);
        chk("step_once",    32'(nhs - n0), 32'd1);

        // 3: wrap-around deltas
        dial = 8'hFE;
        wait_hs(nhs + 1);
        chk("wrap0_val", 32'(hs_val), 32'hFE);
        chk("wrap0_dlt", 32'(hs_dlt), 32'hEB);
        dial = 8'h02;
        wait_hs(nhs + 1);
        chk("wrap1_val", 32'(hs_val), 32'h02);
        chk("wrap1_dlt", 32'(hs_dlt), 32'h04);
        dial = 8'hFD;
        wait_hs(nhs + 1);
        chk("wrap2_val", 32'(hs_val), 32'hFD);
        chk("wrap2_dlt", 32'(hs_dlt), 32'hFB);

        // 4: backpressure freezes data; blocked changes coalesce into the next delta
        dial = 8'h13;
        wait_hs(nhs + 1);
        chk("bp_pre_dlt", 32'(hs_dlt), 32'h16);
        evt_ready = 1'b0;
        dial = 8'h14;
        wait_valid();
        chk("bp_val", 32'(evt_value), 32'h14);
        chk("bp_dlt", 32'(evt_delta), 32'h01);
        r0 = nreads;
        dial = 8'h18;
        tick(80);
        chk("bp_hold_valid", 32'(evt_valid), 32'd1);
        chk("bp_hold_val",   32'(evt_value), 32'h14);
        chk("bp_no_reads",   32'(nreads - r0), 32'd0);
        n0 = nhs;
        evt_ready = 1'b1;
        wait_hs(n0 + 2);
        chk("bp_next_val", 32'(hs_val), 32'h18);
        chk("bp_next_dlt", 32'(hs_dlt), 32'h04);

        // 5: 5-cycle stall with enable dropped during REQ
        tick(1);
        r0 = nreads;
        stall_cfg = 5;
        wait_rd();
        enable = 1'b0;
        tick(3);
        chk("stall_read_held", 32'(avm_read), 32'd1);
        chk("stall_addr",      avm_address,   32'h0);
        tick(40);
        chk("stall_run",     32'(last_rd_run),  32'd6);
        chk("stall_one_rd",  32'(nreads - r0),  32'd1);
        chk("stall_idle_rd", 32'(avm_read),     32'd0);
        stall_cfg = 0;

        // 6: reset during WAIT, then re-prime without an event
        dial   = 8'h77;
        enable = 1'b1;
        wait_rd();
        tick(1);
        reset = 1'b1;
        #1;
        chk("rst6_read",  32'(avm_read),  32'd0);
        chk("rst6_valid", 32'(evt_valid), 32'd0);
        chk("rst6_value", 32'(evt_value), 32'h00);
        chk("rst6_delta", 32'(evt_delta), 32'h00);
        tick(2);
        reset = 1'b0;
        n0 = nhs;
        r0 = nreads;
        tick(30);
        chk("rst6_no_evt",  32'(nhs - n0), 32'd0);
        chk("rst6_resumed", 32'(nreads > r0), 32'd1);
        dial = 8'h70;
        wait_hs(n0 + 1);
        chk("rst6_val", 32'(hs_val), 32'h70);
        chk("rst6_dlt", 32'(hs_dlt), 32'hF9);

`ifdef DIAL_POLLER_DEBOUNCE_EN
        // Debounce: a lone glitch is dropped, a confirmed change emits
        dial = 8'h10;
        wait_hs(nhs + 1);
        chk("db_base_val", 32'(hs_val), 32'h10);
        n0 = nhs;
        wait_acc();
        dial = 8'h50;
        wait_acc();
        dial = 8'h10;
        wait_acc();
        tick(20);
        chk("db_glitch", 32'(nhs - n0), 32'd0);
        dial = 8'h50;
        wait_hs(n0 + 1);
        chk("db_val", 32'(hs_val), 32'h50);
        chk("db_dlt", 32'(hs_dlt), 32'h40);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
